// File: rtl/pcie_ats_inval_flush_tracker_if.sv
// ATS invalidation flush tracker bus bundle.
// Groups the three handshakes the tracker takes part in, plus its status
// outputs:
//   req_*   : decoded invalidation request (FIM -> tracker)
//   flush_* : whole-function flush command and done pulse (tracker <-> cache)
//   cpl_*   : invalidation completion descriptor (tracker -> TX encoder)
//   dup_itag, timeout_err, cpl_count : status/telemetry from the tracker
// The slave modport is the tracker's view; master is the environment's view.
interface pcie_ats_inval_flush_tracker_if #(
  parameter int PF_W = 3,
  parameter int VF_W = 11
);
  logic            req_valid;
  logic            req_ready;
  logic [4:0]      req_itag;
  logic [15:0]     req_rid;
  logic [15:0]     req_dev_id;
  logic [PF_W-1:0] req_pf;
  logic [VF_W-1:0] req_vf;
  logic            req_vf_active;

  logic            flush_valid;
  logic            flush_ready;
  logic [PF_W-1:0] flush_pf;
  logic [VF_W-1:0] flush_vf;
  logic            flush_vf_active;
  logic            flush_done;

  logic            cpl_valid;
  logic            cpl_ready;
  logic [31:0]     cpl_itag_vec;
  logic [15:0]     cpl_rid;
  logic [15:0]     cpl_dest_id;
  logic [2:0]      cpl_cc;
  logic [PF_W-1:0] cpl_pf;
  logic [VF_W-1:0] cpl_vf;
  logic            cpl_vf_active;

  logic            dup_itag;
  logic            timeout_err;
  logic [15:0]     cpl_count;

  modport slave (
    input  req_valid, req_itag, req_rid, req_dev_id, req_pf, req_vf, req_vf_active,
    output req_ready,
    output flush_valid, flush_pf, flush_vf, flush_vf_active,
    input  flush_ready, flush_done,
    output cpl_valid, cpl_itag_vec, cpl_rid, cpl_dest_id, cpl_cc,
    output cpl_pf, cpl_vf, cpl_vf_active,
    input  cpl_ready,
    output dup_itag, timeout_err, cpl_count
  );

  modport master (
    output req_valid, req_itag, req_rid, req_dev_id, req_pf, req_vf, req_vf_active,
    input  req_ready,
    input  flush_valid, flush_pf, flush_vf, flush_vf_active,
    output flush_ready, flush_done,
    input  cpl_valid, cpl_itag_vec, cpl_rid, cpl_dest_id, cpl_cc,
    input  cpl_pf, cpl_vf, cpl_vf_active,
    output cpl_ready,
    input  dup_itag, timeout_err, cpl_count
  );
endinterface

// File: rtl/pcie_ats_inval_flush_tracker.sv
// AFU-side ATS invalidation tracker.
// Accepts decoded invalidation requests, coalesces requests for the same
// function and requester into one conservative whole-function flush of the
// AFU translation cache, waits for the flush to finish (or time out), then
// presents one completion descriptor carrying the merged ITag bitmap.
// Ports:
//   clk  : block clock
//   rst  : asynchronous active-high reset
//   bus  : slave view of pcie_ats_inval_flush_tracker_if (request, flush,
//          completion handshakes and status outputs)
// All outputs are registered except bus.req_ready, which is combinational
// from state, the request fields and flush_ready.
module pcie_ats_inval_flush_tracker #(
  parameter int TIMEOUT = 4096,
  parameter int PF_W    = 3,
  parameter int VF_W    = 11
) (
  input logic clk,
  input logic rst,
  pcie_ats_inval_flush_tracker_if.slave bus
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FLUSH_REQ, FLUSH_WAIT, CPL} state_t;

  state_t          state, state_nxt;

  logic [15:0]     lat_rid;
  logic [15:0]     lat_dev_id;
  logic [PF_W-1:0] lat_pf;
  logic [VF_W-1:0] lat_vf;
  logic            lat_vf_active;
  logic [31:0]     itag_vec;
  logic [15:0]     tmo_cnt;
  logic [15:0]     cpl_cnt;
  logic            flush_valid_q;
  logic            cpl_valid_q;
  logic            dup_q;
  logic            tmo_q;

  logic            req_ready_c;
  logic            accept;
  logic            merge;
  logic            cpl_hs;
  logic            tmo_fire;
  logic            fn_match;
  logic [31:0]     itag_bit;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_nxt   = state;
    req_ready_c = 1'b0;
    tmo_fire    = 1'b0;
    itag_bit    = 32'd1 << bus.req_itag;
    fn_match    = (bus.req_pf == lat_pf) && (bus.req_vf == lat_vf) &&
                  (bus.req_vf_active == lat_vf_active) && (bus.req_rid == lat_rid);
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_nxt = FLUSH_REQ;
      end
      FLUSH_REQ: begin
        // Merging stops on the cycle the flush is taken so a late ITag can
        // never miss the flush it is folded into.
        req_ready_c = fn_match && !bus.flush_ready;
        if (bus.flush_ready) state_nxt = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        // A done pulse on the expiry cycle wins over the timeout.
        if (bus.flush_done) begin
          state_nxt = CPL;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = CPL;
          tmo_fire  = 1'b1;
        end
      end
      CPL: begin
        if (bus.cpl_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = (state == IDLE) && bus.req_valid;
    merge  = (state == FLUSH_REQ) && bus.req_valid && req_ready_c;
    cpl_hs = (state == CPL) && bus.cpl_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Output and context registers, updated from the next-state decision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_rid       <= '0;
      lat_dev_id    <= '0;
      lat_pf        <= '0;
      lat_vf        <= '0;
      lat_vf_active <= 1'b0;
      itag_vec      <= '0;
      tmo_cnt       <= '0;
      cpl_cnt       <= '0;
      flush_valid_q <= 1'b0;
      cpl_valid_q   <= 1'b0;
      dup_q         <= 1'b0;
      tmo_q         <= 1'b0;
    end else begin
      flush_valid_q <= (state_nxt == FLUSH_REQ);
      cpl_valid_q   <= (state_nxt == CPL);
      dup_q         <= merge && ((itag_vec & itag_bit) != 32'd0);
      tmo_q         <= tmo_fire;

      if (accept) begin
        lat_rid       <= bus.req_rid;
        lat_dev_id    <= bus.req_dev_id;
        lat_pf        <= bus.req_pf;
        lat_vf        <= bus.req_vf;
        lat_vf_active <= bus.req_vf_active;
        itag_vec      <= itag_bit;
      end else if (merge) begin
        itag_vec      <= itag_vec | itag_bit;
      end else if (cpl_hs) begin
        itag_vec      <= '0;
      end

      // Held at zero until the flush is taken, so FLUSH_WAIT starts at 0.
      if (state == FLUSH_REQ)       tmo_cnt <= '0;
      else if (state == FLUSH_WAIT) tmo_cnt <= tmo_cnt + 16'd1;

      if (cpl_hs) cpl_cnt <= sat_inc16(cpl_cnt);
    end
  end

  assign bus.req_ready       = req_ready_c;
  assign bus.flush_valid     = flush_valid_q;
  assign bus.flush_pf        = lat_pf;
  assign bus.flush_vf        = lat_vf;
  assign bus.flush_vf_active = lat_vf_active;
  assign bus.cpl_valid       = cpl_valid_q;
  assign bus.cpl_itag_vec    = itag_vec;
  // The completion travels back toward the invalidating root complex.
  assign bus.cpl_rid         = lat_dev_id;
  assign bus.cpl_dest_id     = lat_rid;
  assign bus.cpl_cc          = 3'd1;
  assign bus.cpl_pf          = lat_pf;
  assign bus.cpl_vf          = lat_vf;
  assign bus.cpl_vf_active   = lat_vf_active;
  assign bus.dup_itag        = dup_q;
  assign bus.timeout_err     = tmo_q;
  assign bus.cpl_count       = cpl_cnt;

endmodule

// File: tb/tb_pcie_ats_inval_flush_tracker.sv
module tb_pcie_ats_inval_flush_tracker;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pcie_ats_inval_flush_tracker_if #(.PF_W(3), .VF_W(11)) bus();

  pcie_ats_inval_flush_tracker #(.TIMEOUT(TMO), .PF_W(3), .VF_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] vec;
    logic [15:0] rid;
    logic [15:0] dest;
    logic [2:0]  pf;
    logic [10:0] vf;
    logic        vfa;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int nflush = 0;
  int ndup = 0;
  int ntmo = 0;

  always @(posedge clk) begin
    if (bus.flush_valid && bus.flush_ready) nflush <= nflush + 1;
    if (bus.dup_itag) ndup <= ndup + 1;
    if (bus.timeout_err) ntmo <= ntmo + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_req(input logic [4:0] itag, input logic [15:0] rid, input logic [15:0] dev,
                           input logic [2:0] pf, input logic [10:0] vf, input logic vfa);
    bus.req_itag      = itag;
    bus.req_rid       = rid;
    bus.req_dev_id    = dev;
    bus.req_pf        = pf;
    bus.req_vf        = vf;
    bus.req_vf_active = vfa;
    bus.req_valid     = 1'b1;
  endtask

  // Offers a request until accepted; updates the scoreboard model (new group
  // or merge into the newest pending group) and checks the dup_itag pulse.
  task automatic send_req(input string tag, input logic [4:0] itag, input logic [15:0] rid,
                          input logic [15:0] dev, input logic [2:0] pf, input logic [10:0] vf,
                          input logic vfa, input bit new_grp);
    int n;
    exp_t e;
    logic exp_dup;
    drive_req(itag, rid, dev, pf, vf, vfa);
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(bus.req_ready), 32'd1);
    exp_dup = 1'b0;
    if (new_grp || sbq.size() == 0) begin
      e.vec  = 32'd1 << itag;
      e.rid  = dev;
      e.dest = rid;
      e.pf   = pf;
      e.vf   = vf;
      e.vfa  = vfa;
      sbq.push_back(e);
    end else begin
      e = sbq[sbq.size()-1];
      exp_dup = e.vec[itag];
      e.vec = e.vec | (32'd1 << itag);
      sbq[sbq.size()-1] = e;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk({tag, "_dup"}, 32'(bus.dup_itag), 32'(exp_dup));
  endtask

  task automatic wait_flush(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.flush_valid && bus.flush_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_flush_hs"}, 32'(bus.flush_valid && bus.flush_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bus.flush_done = 1'b1;
    tick(1);
    bus.flush_done = 1'b0;
  endtask

  task automatic finish_cpl(input string tag);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.cpl_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_cpl_valid"}, 32'(bus.cpl_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sbq.size()), 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_vec"},  bus.cpl_itag_vec, e.vec);
      chk({tag, "_rid"},  32'(bus.cpl_rid), 32'(e.rid));
      chk({tag, "_dest"}, 32'(bus.cpl_dest_id), 32'(e.dest));
      chk({tag, "_cc"},   32'(bus.cpl_cc), 32'd1);
      chk({tag, "_fn"},   32'({bus.cpl_pf, bus.cpl_vf, bus.cpl_vf_active}),
                          32'({e.pf, e.vf, e.vfa}));
    end
    bus.cpl_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.cpl_ready = 1'b0;
    exp_cnt++;
    chk({tag, "_count"}, 32'(bus.cpl_count), 32'(exp_cnt));
    chk({tag, "_cpl_drop"}, 32'(bus.cpl_valid), 32'd0);
    chk({tag, "_rdy_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int f0, d0, t0, n;
    logic [31:0] s_vec;
    logic [15:0] s_rid, s_dest, s_cnt;
    logic [14:0] s_fn;
    logic stable, never_rdy;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_itag = '0;
    bus.req_rid = '0;
    bus.req_dev_id = '0;
    bus.req_pf = '0;
    bus.req_vf = '0;
    bus.req_vf_active = 1'b0;
    bus.flush_ready = 1'b0;
    bus.flush_done = 1'b0;
    bus.cpl_ready = 1'b0;
    tick(2);
    chk("rst_flush_valid", 32'(bus.flush_valid), 32'd0);
    chk("rst_cpl_valid",   32'(bus.cpl_valid), 32'd0);
    chk("rst_dup",         32'(bus.dup_itag), 32'd0);
    chk("rst_tmo",         32'(bus.timeout_err), 32'd0);
    chk("rst_count",       32'(bus.cpl_count), 32'd0);
    chk("rst_vec",         bus.cpl_itag_vec, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_req_ready",  32'(bus.req_ready), 32'd1);

    // Single request
    bus.flush_ready = 1'b1;
    send_req("t1", 5'd5, 16'h0000, 16'h0100, 3'd0, 11'd0, 1'b0, 1'b1);
    chk("t1_flush_lat", 32'(bus.flush_valid), 32'd1);
    chk("t1_flush_pf",  32'(bus.flush_pf), 32'd0);
    wait_flush("t1");
    tick(2);
    pulse_done();
    chk("t1_cpl_lat", 32'(bus.cpl_valid), 32'd1);
    finish_cpl("t1");
    chk("t1_nflush", 32'(nflush), 32'd1);

    // Coalescing with a duplicate ITag
    bus.flush_ready = 1'b0;
    f0 = nflush;
    d0 = ndup;
    send_req("t2a", 5'd1, 16'h0010, 16'h0200, 3'd0, 11'd3, 1'b1, 1'b1);
    send_req("t2b", 5'd2, 16'h0010, 16'h0200, 3'd0, 11'd3, 1'b1, 1'b0);
    send_req("t2c", 5'd1, 16'h0010, 16'h0200, 3'd0, 11'd3, 1'b1, 1'b0);
    chk("t2_flush_held", 32'(bus.flush_valid), 32'd1);
    bus.flush_ready = 1'b1;
    wait_flush("t2");
    pulse_done();
    finish_cpl("t2");
    chk("t2_one_flush", 32'(nflush - f0), 32'd1);
    chk("t2_one_dup",   32'(ndup - d0), 32'd1);

    // Mismatched function stalls until the next IDLE
    bus.flush_ready = 1'b0;
    f0 = nflush;
    send_req("t3a", 5'd3, 16'h0020, 16'h0300, 3'd0, 11'd0, 1'b0, 1'b1);
    drive_req(5'd4, 16'h0020, 16'h0301, 3'd1, 11'd0, 1'b0);
    @(negedge clk);
    chk("t3_stall_freq", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush_ready = 1'b1;
    wait_flush("t3a");
    chk("t3_stall_fwait", 32'(bus.req_ready), 32'd0);
    pulse_done();
    chk("t3_stall_cpl", 32'(bus.req_ready), 32'd0);
    finish_cpl("t3a");
    send_req("t3b", 5'd4, 16'h0020, 16'h0301, 3'd1, 11'd0, 1'b0, 1'b1);
    chk("t3b_flush_pf", 32'(bus.flush_pf), 32'd1);
    wait_flush("t3b");
    pulse_done();
    finish_cpl("t3b");
    chk("t3_two_flush", 32'(nflush - f0), 32'd2);

    // Timeout with no flush_done
    send_req("t4", 5'd7, 16'h0030, 16'h0400, 3'd2, 11'd0, 1'b0, 1'b1);
    wait_flush("t4");
    t0 = ntmo;
    n = 0;
    while (!bus.cpl_valid && n < 3 * TMO) begin
      tick(1);
      n++;
    end
    chk("t4_tmo_latency", 32'(n), 32'(TMO));
    chk("t4_tmo_err", 32'(bus.timeout_err), 32'd1);
    finish_cpl("t4");
    tick(1);
    chk("t4_one_tmo", 32'(ntmo - t0), 32'd1);

    // flush_done on the expiry cycle counts as done
    send_req("t4b", 5'd9, 16'h0030, 16'h0400, 3'd2, 11'd0, 1'b0, 1'b1);
    wait_flush("t4b");
    t0 = ntmo;
    tick(TMO - 1);
    pulse_done();
    chk("t4b_cpl", 32'(bus.cpl_valid), 32'd1);
    chk("t4b_no_tmo", 32'(bus.timeout_err), 32'd0);
    finish_cpl("t4b");
    tick(1);
    chk("t4b_tmo_cnt", 32'(ntmo - t0), 32'd0);

    // Completion backpressure
    send_req("t5", 5'd0, 16'h0040, 16'h0500, 3'd3, 11'd5, 1'b1, 1'b1);
    wait_flush("t5");
    pulse_done();
    s_vec  = bus.cpl_itag_vec;
    s_rid  = bus.cpl_rid;
    s_dest = bus.cpl_dest_id;
    s_fn   = {bus.cpl_pf, bus.cpl_vf, bus.cpl_vf_active};
    s_cnt  = bus.cpl_count;
    drive_req(5'd2, 16'h0040, 16'h0500, 3'd3, 11'd5, 1'b1);
    stable = 1'b1;
    never_rdy = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.cpl_valid || bus.cpl_itag_vec !== s_vec || bus.cpl_rid !== s_rid ||
          bus.cpl_dest_id !== s_dest || {bus.cpl_pf, bus.cpl_vf, bus.cpl_vf_active} !== s_fn ||
          bus.cpl_count !== s_cnt)
        stable = 1'b0;
      if (bus.req_ready !== 1'b0) never_rdy = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("t5_stable", 32'(stable), 32'd1);
    chk("t5_no_ready", 32'(never_rdy), 32'd1);
    finish_cpl("t5");
    chk("t5_count_once", 32'(bus.cpl_count), 32'(s_cnt) + 32'd1);

    // Reset during FLUSH_WAIT
    send_req("t6", 5'd11, 16'h0050, 16'h0600, 3'd1, 11'd0, 1'b0, 1'b1);
    wait_flush("t6");
    tick(2);
    rst = 1'b1;
    #1;
    chk("t6_flush_valid", 32'(bus.flush_valid), 32'd0);
    chk("t6_cpl_valid",   32'(bus.cpl_valid), 32'd0);
    chk("t6_count",       32'(bus.cpl_count), 32'd0);
    chk("t6_vec",         bus.cpl_itag_vec, 32'd0);
    chk("t6_flush_pf",    32'(bus.flush_pf), 32'd0);
    chk("t6_cpl_rid",     32'(bus.cpl_rid), 32'd0);
    sbq.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(3);
    chk("t6_no_cpl", 32'(bus.cpl_valid), 32'd0);
    send_req("t6b", 5'd12, 16'h0060, 16'h0700, 3'd0, 11'd0, 1'b0, 1'b1);
    wait_flush("t6b");
    pulse_done();
    finish_cpl("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
